prod_engine: RTL and testbench

Hardware responder for the program-3 double-precision multiply job. On a `start` request it walks the byte-wide data memory, reads 16 pairs of big-endian signed 16-bit operands from bytes 0..63, computes each 32-bit signed product with an iterative Booth multiplier, and writes the products big-endian to bytes 64..127. It then raises `done`. It sits beside the data memory in `top_level` as the executor that the program-3 bench drives and checks.

---
 rtl/prod_engine_pkg.sv | 28 ++
 rtl/booth_mul16.sv | 59 +++++
 rtl/prod_engine.sv | 155 +++++++++++++++
 tb/tb_prod_engine.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prod_engine_pkg.sv
// Shared types and constants for the program-3 product engine.
package prod_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        STORE,
        DONE
    } pe_state_t;

    localparam int PE_BYTES_PER_OPND = 2;
    localparam int PE_BYTES_PER_PROD = 4;
    localparam int PE_MUL_ITERS      = 16;

    // Big-endian byte k of a 32-bit product (k=0 is the most significant byte).
    function automatic logic [7:0] pe_prod_byte(input logic [31:0] p, input logic [1:0] k);
        logic [7:0] b;
        unique case (k)
            2'd0:    b = p[31:24];
            2'd1:    b = p[23:16];
            2'd2:    b = p[15:8];
            default: b = p[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/booth_mul16.sv
// Iterative radix-2 Booth multiplier, 16x16 signed -> 32-bit, one step per clock.
// The go cycle performs the first step, so valid flags the 16th step.
module booth_mul16
    import prod_engine_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p,
    output logic               valid
);

    // acc = {hi[16:0], multiplier[15:0], q_minus1}; hi carries one guard bit
    logic [33:0] acc_q, acc_d, src;
    logic [16:0] hi_sum;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    always_comb begin
        src    = go ? {17'd0, a, 1'b0} : acc_q;
        hi_sum = src[33:17];
        unique case (src[1:0])
            2'b01:   hi_sum = src[33:17] + {b[15], b};
            2'b10:   hi_sum = src[33:17] - {b[15], b};
            default: hi_sum = src[33:17];
        endcase

        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (go) begin
            acc_d = {hi_sum[16], hi_sum, src[16:1]};
            cnt_d = 4'(PE_MUL_ITERS - 2);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = {hi_sum[16], hi_sum, src[16:1]};
            if (cnt_q == 4'd0) run_d = 1'b0;
            else               cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign valid = run_q && (cnt_q == 4'd0);
    assign p     = acc_q[32:1];

endmodule

// File: rtl/prod_engine.sv
// Program-3 product engine: reads operand pairs from data memory, multiplies, writes products back.
// PROD_ENGINE_FAST_MUL_EN selects a single-cycle combinational multiply instead of booth_mul16.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | reading 4 operand bytes of pair j
//   MUL   | forming B*A
//   STORE | writing 4 product bytes of pair j
//   DONE  | job complete, held while start stays high
module prod_engine
    import prod_engine_pkg::*;
#(
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    mem_wr_data,
    output logic          mem_we
);

    localparam int         JW     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [3:0] LAST_K = 4'(PE_BYTES_PER_PROD - 1);

    pe_state_t      state_q, state_d;
    logic [JW-1:0]  j_q, j_d;
    logic [3:0]     k_q, k_d;
    logic [15:0]    a_q, a_d, b_q, b_d;
    logic [AW-1:0]  byte_off;
    logic [31:0]    prod;
    logic           mul_done;

    assign byte_off = AW'({j_q, k_q[1:0]});

`ifdef PROD_ENGINE_FAST_MUL_EN
    logic [31:0] prod_q, prod_d;

    assign prod_d   = (state_q == MUL) ? {{16{a_q[15]}}, a_q} * {{16{b_q[15]}}, b_q} : prod_q;
    assign prod     = prod_q;
    assign mul_done = 1'b1;
`else
    logic mul_go;

    assign mul_go = (state_q == MUL) && (k_q == 4'd0);

    booth_mul16 u_mul (
        .clk   (clk),
        .reset (reset),
        .go    (mul_go),
        .a     (a_q),
        .b     (b_q),
        .p     (prod),
        .valid (mul_done)
    );
`endif

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                mem_addr = AW'(SRC_BASE) + byte_off;
                unique case (k_q[1:0])
                    2'd0:    a_d[15:8] = mem_rd_data;
                    2'd1:    a_d[7:0]  = mem_rd_data;
                    2'd2:    b_d[15:8] = mem_rd_data;
                    default: b_d[7:0]  = mem_rd_data;
                endcase
                if (k_q == LAST_K) begin
                    state_d = MUL;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            MUL: begin
                busy = 1'b1;
                k_d  = k_q + 4'd1;
                if (mul_done) begin
                    state_d = STORE;
                    k_d     = '0;
                end
            end
            STORE: begin
                busy        = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = AW'(DST_BASE) + byte_off;
                mem_wr_data = pe_prod_byte(prod, k_q[1:0]);
                if (k_q == LAST_K) begin
                    k_d = '0;
                    if (j_q == JW'(NUM_PAIRS - 1)) begin
                        state_d = DONE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = LOAD;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef PROD_ENGINE_FAST_MUL_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef PROD_ENGINE_FAST_MUL_EN
            prod_q  <= prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_prod_engine.sv
// Directed self-checking bench for prod_engine with a byte-wide memory model.
module tb_prod_engine;

`ifdef PROD_ENGINE_FAST_MUL_EN
    localparam int PER = 9;
`else
    localparam int PER = 24;
`endif
    localparam int NP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, mem_we;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

    logic [7:0] src [64];
    logic [7:0] dst [64];
    logic       clr_dst = 1'b0;
    int         cyc = 0;
    int         wr64_cyc = -1;
    int         stray = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    prod_engine dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .mem_we      (mem_we)
    );

    assign mem_rd_data = (mem_addr < 8'd64) ? src[mem_addr[5:0]] : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_dst) begin
            for (int i = 0; i < 64; i++) dst[i] <= 8'hEE;
        end else if (mem_we) begin
            if (mem_addr[7:6] == 2'b01) dst[mem_addr[5:0]] <= mem_wr_data;
            else                        stray <= stray + 1;
            if (mem_addr == 8'd64) wr64_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (reset === 1'b1) chk("busy_done_excl", 32'(busy & done), 32'd0);

    function automatic logic [31:0] ref_prod(input int j);
        logic signed [15:0] a, b;
        a = {src[4*j], src[4*j+1]};
        b = {src[4*j+2], src[4*j+3]};
        return 32'(int'(a) * int'(b));
    endfunction

    function automatic logic [31:0] got_prod(input int j);
        return {dst[4*j], dst[4*j+1], dst[4*j+2], dst[4*j+3]};
    endfunction

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_dst();
        @(negedge clk) clr_dst = 1'b1;
        @(negedge clk) clr_dst = 1'b0;
    endtask

    task automatic start_job(output int e);
        @(negedge clk) start = 1'b1;
        @(posedge clk) e = cyc;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int e, input string tag);
        int n = 0;
        while (!done && n < PER * NP + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, cyc - 1 - e, PER * NP);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < NP; j++)
            chk($sformatf("%s_p%0d", tag, j), got_prod(j), ref_prod(j));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wr_data), 32'd0);
    endtask

    initial begin
        int e;
        logic [31:0] r;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
        {src[0], src[1], src[2], src[3]}     = 32'h0003_FFFE;
        {src[4], src[5], src[6], src[7]}     = 32'h8000_8000;
        {src[8], src[9], src[10], src[11]}   = 32'h8000_7FFF;
        {src[12], src[13], src[14], src[15]} = 32'h0000_1234;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk) reset = 1'b1;
        clear_dst();

        // Job 1: mid-job start pulse ignored, start held across DONE
        start_job(e);
        chk("job1_busy_after_start", 32'(busy), 32'd1);
        chk("job1_done_after_start", 32'(done), 32'd0);
        skip(PER * NP / 4);
        start = 1'b1;
        skip(1);
        start = 1'b0;
        chk("job1_busy_after_pulse", 32'(busy), 32'd1);
        skip(PER * NP / 2);
        start = 1'b1;
        wait_done(e, "job1");
        chk("job1_first_write_edge", wr64_cyc - e, PER - 3);
        chk("pair0_3x-2", got_prod(0), 32'hFFFF_FFFA);
        chk("pair1_min_min", got_prod(1), 32'h4000_0000);
        chk("pair2_min_max", got_prod(2), 32'hC000_8000);
        chk("pair3_zero", got_prod(3), 32'h0000_0000);
        check_all("job1");
        chk("job1_stray_writes", stray, 0);
        skip(5);
        chk("done_held", 32'(done), 32'd1);
        chk("busy_low_held", 32'(busy), 32'd0);
        start = 1'b0;
        skip(1);
        check_outputs_zero("idle_after_drop");

        // Job 2: identical rerun
        clear_dst();
        start_job(e);
        wait_done(e, "job2");
        check_all("job2");

        // Job 3: reset during pair 5 multiply
        skip(2);
        clear_dst();
        start_job(e);
        skip(PER * 5 + 4);
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("midjob_reset");
        for (int i = 0; i < 20; i++) begin
            r = ref_prod(i / 4);
            chk($sformatf("kept_byte%0d", 64 + i), 32'(dst[i]), 32'(r[31 - 8 * (i % 4) -: 8]));
        end
        for (int i = 20; i < 24; i++)
            chk($sformatf("unwritten_byte%0d", 64 + i), 32'(dst[i]), 32'hEE);
        @(negedge clk) reset = 1'b1;

        clear_dst();
        start_job(e);
        wait_done(e, "job4");
        check_all("job4");
        chk("final_stray_writes", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
